// File: rtl/mac_seq_pkg.sv
// Shared types for the dot-product sequencer: MAC lane geometry, the
// pipeline tag that rides alongside each operand beat, and the FSM states.
package mac_seq_pkg;

  localparam int MAC_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int MAC_RES_W = 18;

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/mac_seq_result_fifo.sv
// Synchronous result FIFO (power-of-two depth) with an occupancy count used
// by the sequencer's credit logic. Head entry is presented combinationally.
module mac_seq_result_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  // storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  end

  mac_seq_result_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_i),
    .pop_i   (do_pop),
    .count_i (cnt_q)
  );

endmodule

// File: rtl/mac_seq_result_fifo_chk.sv
// Protocol checker for the result FIFO: a push into a full FIFO must always
// be paired with a pop, since upstream credits are meant to prevent overflow.
module mac_seq_result_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                     clk_i,
  input logic                     rst_n_i,
  input logic                     push_i,
  input logic                     pop_i,
  input logic [$clog2(DEPTH):0]   count_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push_i && !pop_i && (count_i == CW'(DEPTH))));

endmodule

// File: rtl/mac_dot_product_sequencer.sv
// Feeds int8x4 beats to an external pipelined MAC, realigns its partial sums
// with a tag pipe, accumulates per vector and queues one result per vector.
module mac_dot_product_sequencer
  import mac_seq_pkg::*;
#(
  parameter int MAC_LATENCY = 3,
  parameter int ACC_W       = 32,
  parameter int RES_DEPTH   = 4,
  parameter int SATURATE    = 1
) (
  input  logic                        clock0,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAC_LANES*LANE_W-1:0] in_a,
  input  logic [MAC_LANES*LANE_W-1:0] in_b,
  input  logic                        in_last,
  output logic [LANE_W-1:0]           mac_dataa_0,
  output logic [LANE_W-1:0]           mac_dataa_1,
  output logic [LANE_W-1:0]           mac_dataa_2,
  output logic [LANE_W-1:0]           mac_dataa_3,
  output logic [LANE_W-1:0]           mac_datab_0,
  output logic [LANE_W-1:0]           mac_datab_1,
  output logic [LANE_W-1:0]           mac_datab_2,
  output logic [LANE_W-1:0]           mac_datab_3,
  input  logic [MAC_RES_W-1:0]        mac_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        out_sat,
  output logic                        busy
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             sat;
  } res_t;

  // Returns {overflow, result}; clamps to the signed ACC_W range when saturating.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [MAC_RES_W-1:0] term);
    logic [ACC_W:0] wide;
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-MAC_RES_W){term[MAC_RES_W-1]}}, term};
    if ((SATURATE != 0) && (wide[ACC_W] != wide[ACC_W-1])) begin
      sat_add = {1'b1, wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
    end else begin
      sat_add = {1'b0, wide[ACC_W-1:0]};
    end
  endfunction

  logic                        accept;
  logic                        push;
  logic                        pop;
  logic                        tags_busy;
  tag_t                        new_tag;
  tag_t [MAC_LATENCY:0]        tag_q;
  tag_t                        rtag_q;
  logic [MAC_RES_W-1:0]        rmac_q;
  logic [MAC_LANES*LANE_W-1:0] a_q;
  logic [MAC_LANES*LANE_W-1:0] b_q;
  logic [CW-1:0]               lif_q;
  logic [CW-1:0]               lif_d;
  logic [CW-1:0]               fifo_count;
  state_t                      state_q;
  state_t                      state_d;
  logic [ACC_W-1:0]            acc_q;
  logic [ACC_W-1:0]            acc_d;
  logic                        sat_q;
  logic                        sat_d;
  logic [ACC_W-1:0]            base_acc;
  logic                        base_sat;
  logic [ACC_W:0]              sum_w;
  res_t                        push_data;
  res_t                        head;

  // Credits: FIFO slots not yet claimed by a stored result or a last beat in flight.
  assign in_ready     = (fifo_count + lif_q) < CW'(RES_DEPTH);
  assign accept       = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign new_tag.v    = accept;
  assign new_tag.last = accept && in_last;
  assign lif_d        = lif_q + CW'(new_tag.last) - CW'(push);

  assign mac_dataa_0 = a_q[7:0];
  assign mac_dataa_1 = a_q[15:8];
  assign mac_dataa_2 = a_q[23:16];
  assign mac_dataa_3 = a_q[31:24];
  assign mac_datab_0 = b_q[7:0];
  assign mac_datab_1 = b_q[15:8];
  assign mac_datab_2 = b_q[23:16];
  assign mac_datab_3 = b_q[31:24];

  // operand drive, tag pipe and registered MAC result (tag and sum meet in rtag_q/rmac_q)
  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      rtag_q <= '0;
      rmac_q <= '0;
      lif_q  <= '0;
    end else begin
      a_q    <= accept ? in_a : '0;
      b_q    <= accept ? in_b : '0;
      tag_q  <= {tag_q[MAC_LATENCY-1:0], new_tag};
      rtag_q <= tag_q[MAC_LATENCY];
      rmac_q <= mac_result;
      lif_q  <= lif_d;
    end
  end

  // accumulator state register
  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  // accumulator next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rtag_q.v && !rtag_q.last) state_d = S_ACC;
        else                          state_d = S_IDLE;
      end
      S_ACC: begin
        if (rtag_q.v && rtag_q.last) state_d = S_IDLE;
        else                         state_d = S_ACC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // accumulator datapath; in S_IDLE the running sum starts from zero
  always_comb begin
    base_acc       = (state_q == S_ACC) ? acc_q : '0;
    base_sat       = (state_q == S_ACC) && sat_q;
    sum_w          = sat_add(base_acc, rmac_q);
    push_data.data = sum_w[ACC_W-1:0];
    push_data.sat  = base_sat | sum_w[ACC_W];
    push           = rtag_q.v && rtag_q.last;
    if (rtag_q.v && !rtag_q.last) begin
      acc_d = push_data.data;
      sat_d = push_data.sat;
    end else if (rtag_q.v) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else begin
      acc_d = acc_q;
      sat_d = sat_q;
    end
  end

  // any beat still travelling through the MAC alignment pipe
  always_comb begin
    tags_busy = rtag_q.v;
    for (int i = 0; i <= MAC_LATENCY; i++) tags_busy = tags_busy | tag_q[i].v;
  end

  assign busy      = tags_busy || (lif_q != '0) || (state_q == S_ACC) || out_valid;
  assign out_valid = (fifo_count != '0);
  assign out_data  = head.data;
  assign out_sat   = head.sat;

  mac_seq_result_fifo #(.W(ACC_W + 1), .DEPTH(RES_DEPTH)) u_fifo (
    .clk_i   (clock0),
    .rst_n_i (resetn),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// Directed bench for mac_dot_product_sequencer with a behavioural int8x4 MAC.
module tb_mac_dot_product_sequencer;

  localparam int L     = 3;
  localparam int AW    = 20;
  localparam int DEPTH = 8;

  logic          clock0 = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          in_ready, out_valid, out_sat, busy;
  logic [7:0]    da0, da1, da2, da3, db0, db1, db2, db3;
  logic [17:0]   mac_result;
  logic [AW-1:0] out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic last_acc = 1'b0;
  logic [AW:0] got_q[$];
  int got_cyc[$];

  always #5 clock0 = ~clock0;

  mac_dot_product_sequencer #(.MAC_LATENCY(L), .ACC_W(AW), .RES_DEPTH(DEPTH), .SATURATE(1)) dut (
    .clock0(clock0), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_dataa_0(da0), .mac_dataa_1(da1), .mac_dataa_2(da2), .mac_dataa_3(da3),
    .mac_datab_0(db0), .mac_datab_1(db1), .mac_datab_2(db2), .mac_datab_3(db3),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  a10_mac_8bitx4 #(.LATENCY(L)) u_mac (
    .clock0(clock0),
    .dataa_0(da0), .dataa_1(da1), .dataa_2(da2), .dataa_3(da3),
    .datab_0(db0), .datab_1(db1), .datab_2(db2), .datab_3(db3),
    .result(mac_result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [AW:0] take();
    if (got_q.size() == 0) return '1;
    return got_q.pop_front();
  endfunction

  // Inputs are set at a negedge; record what the coming posedge will transfer.
  task automatic tick();
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got_q.push_back({out_sat, out_data});
      got_cyc.push_back(cyc);
    end
    @(negedge clock0);
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 100);
    if (!last_acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
  endtask

  task automatic clear();
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, guard, k;
    logic [AW:0] r;

    repeat (3) @(negedge clock0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    resetn = 1'b1;
    @(negedge clock0);
    check("rst_outputs", {out_valid, out_sat, busy, out_data}, 64'd0);
    check("rst_mac_data", {da0, da1, da2, da3, db0, db1, db2, db3}, 64'd0);

    // 1: three-beat vector, latency from first accept
    out_ready = 1'b1;
    clear();
    c0 = cyc;
    send(lanes(1, 2, 3, 4), lanes(1, 2, 3, 4), 1'b0);
    send(lanes(1, 2, 3, 4), lanes(1, 2, 3, 4), 1'b0);
    send(lanes(1, 2, 3, 4), lanes(1, 2, 3, 4), 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    check("t1_latency", cyc - c0 - 1, L + 4);
    drain(3);
    check("t1_count", got_q.size(), 1);
    r = take();
    check("t1_data", r[AW-1:0], 90);
    check("t1_sat", r[AW], 1'b0);

    // 2: back-to-back single-beat vectors at full rate
    clear();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(32'h8080_8080, 32'h8080_8080, 1'b1);
    check("t2_accept_cycles", cyc - c0, 8);
    drain(12);
    check("t2_count", got_q.size(), 8);
    check("t2_out_span", (got_cyc.size() == 8) ? (got_cyc[7] - got_cyc[0]) : -1, 7);
    for (int i = 0; i < 8; i++) begin
      r = take();
      check("t2_data", {r[AW], r[AW-1:0]}, {1'b0, 20'd65536});
    end

    // 3: backpressure, credits limit acceptance to the FIFO depth
    clear();
    out_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 30; t++) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_a = lanes(k + 1, 0, 0, 0); in_b = lanes(1, 0, 0, 0);
      tick();
      if (last_acc) k++;
    end
    check("t3_accepted", k, DEPTH);
    check("t3_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    guard = 0;
    while (k < DEPTH + 2 && guard < 100) begin
      in_valid = 1'b1; in_last = 1'b1;
      in_a = lanes(k + 1, 0, 0, 0); in_b = lanes(1, 0, 0, 0);
      tick();
      if (last_acc) k++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain(20);
    check("t3_count", got_q.size(), DEPTH + 2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      r = take();
      check("t3_order", r[AW-1:0], i + 1);
    end

    // 4: saturation is sticky for the vector, clears for the next one
    clear();
    for (int i = 0; i < 10; i++) send(lanes(127, 127, 127, 127), lanes(127, 127, 127, 127), i == 9);
    send(lanes(1, 0, 0, 0), lanes(1, 0, 0, 0), 1'b1);
    drain(15);
    check("t4_count", got_q.size(), 2);
    r = take();
    check("t4_sat_data", r[AW-1:0], 524287);
    check("t4_sat_flag", r[AW], 1'b1);
    r = take();
    check("t4_next_data", r[AW-1:0], 1);
    check("t4_next_flag", r[AW], 1'b0);

    // 5: input bubbles inside a vector
    clear();
    for (int i = 0; i < 4; i++) begin
      send(lanes(2, 2, 2, 2), lanes(3, 3, 3, 3), i == 3);
      if (i < 3) tick();
    end
    drain(15);
    check("t5_count", got_q.size(), 1);
    r = take();
    check("t5_data", {r[AW], r[AW-1:0]}, {1'b0, 20'd96});

    // 6: reset with one queued result and two beats in flight
    clear();
    out_ready = 1'b0;
    send(lanes(5, 0, 0, 0), lanes(1, 0, 0, 0), 1'b1);
    drain(8);
    check("t6_queued", out_valid, 1'b1);
    send(lanes(7, 7, 7, 7), lanes(7, 7, 7, 7), 1'b0);
    send(lanes(7, 7, 7, 7), lanes(7, 7, 7, 7), 1'b0);
    check("t6_busy", busy, 1'b1);
    resetn = 1'b0;
    drain(2);
    check("t6_rst_outputs", {out_valid, out_sat, busy, out_data}, 64'd0);
    check("t6_rst_mac_data", {da0, da1, da2, da3, db0, db1, db2, db3}, 64'd0);
    check("t6_rst_in_ready", in_ready, 1'b1);
    resetn = 1'b1;
    out_ready = 1'b1;
    clear();
    drain(10);
    send(lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1);
    drain(15);
    check("t6_count", got_q.size(), 1);
    r = take();
    check("t6_data", {r[AW], r[AW-1:0]}, {1'b0, 20'd4});
    check("t6_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// Behavioural int8x4 multiply-add with LATENCY registered stages.
module a10_mac_8bitx4 #(
  parameter int LATENCY = 3
) (
  input  logic        clock0,
  input  logic [7:0]  dataa_0,
  input  logic [7:0]  dataa_1,
  input  logic [7:0]  dataa_2,
  input  logic [7:0]  dataa_3,
  input  logic [7:0]  datab_0,
  input  logic [7:0]  datab_1,
  input  logic [7:0]  datab_2,
  input  logic [7:0]  datab_3,
  output logic [17:0] result
);

  logic signed [17:0] stage [LATENCY];

  always @(posedge clock0) begin
    stage[0] <= $signed(dataa_0) * $signed(datab_0) + $signed(dataa_1) * $signed(datab_1)
              + $signed(dataa_2) * $signed(datab_2) + $signed(dataa_3) * $signed(datab_3);
    for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
  end

  assign result = stage[LATENCY-1];

endmodule
